// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID operand collector with EX/MEM/WB forwarding, load-use stall and ID/EX register (optional ID_EX_PERF_CNT_EN perf counters)
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_rd_we,
  input  logic            id_is_load,
  output logic [RA_W-1:0] rR1,
  output logic [RA_W-1:0] rR2,
  input  logic [XLEN-1:0] rD1,
  input  logic [XLEN-1:0] rD2,
  input  logic [XLEN-1:0] ex_wD,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_rd_we,
  input  logic [XLEN-1:0] mem_wD,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_rd_we,
  input  logic [XLEN-1:0] wb_wD,
  input  logic            flush,
  input  logic            hold,
  output logic            stall_if_id,
  output logic            ex_valid,
  output logic            ex_rd_we,
  output logic            ex_is_load,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
`endif
  output logic [RA_W-1:0] ex_rd
);
  logic            valid_q, valid_d, rd_we_q, rd_we_d, is_load_q, is_load_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d, op1_q, op1_d, op2_q, op2_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] op1, op2;
  logic            load_use, ex_fwd_ok;

  assign rR1 = id_rs1;
  assign rR2 = id_rs2;
  assign ex_fwd_ok = valid_q & rd_we_q & ~is_load_q;

  function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] rs, input logic used, input logic [XLEN-1:0] rf);
    return (rs == '0) ? '0 :
           !used ? rf :
           (ex_fwd_ok && rd_q == rs) ? ex_wD :
           (mem_rd_we && mem_rd == rs) ? mem_wD :
           (wb_rd_we && wb_rd == rs) ? wb_wD : rf;
  endfunction

  // operand resolution and hazard detection
  always_comb begin
    op1 = fwd(id_rs1, id_rs1_used, rD1);
    op2 = fwd(id_rs2, id_rs2_used, rD2);
    load_use = valid_q & is_load_q & rd_we_q & (rd_q != '0) & id_valid &
               ((id_rs1_used & (id_rs1 == rd_q)) | (id_rs2_used & (id_rs2 == rd_q)));
    stall_if_id = (load_use | hold) & ~flush;
  end

  // ID/EX next state: flush bubble, then hold, then load-use bubble, else capture
  always_comb begin
    {valid_d, rd_we_d, is_load_d} = {valid_q, rd_we_q, is_load_q};
    {pc_d, imm_d, op1_d, op2_d, rd_d} = {pc_q, imm_q, op1_q, op2_q, rd_q};
    if (flush || (!hold && load_use)) begin
      {valid_d, rd_we_d, is_load_d} = 3'b000;
    end else if (!hold) begin
      {valid_d, rd_we_d, is_load_d} = {id_valid, id_valid & id_rd_we, id_valid & id_is_load};
      {pc_d, imm_d, op1_d, op2_d, rd_d} = {id_pc, id_imm, op1, op2, id_rd};
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {valid_q, rd_we_q, is_load_q} <= 3'b000;
      {pc_q, imm_q, op1_q, op2_q, rd_q} <= '0;
    end else begin
      {valid_q, rd_we_q, is_load_q} <= {valid_d, rd_we_d, is_load_d};
      {pc_q, imm_q, op1_q, op2_q, rd_q} <= {pc_d, imm_d, op1_d, op2_d, rd_d};
    end
  end

  assign {ex_valid, ex_rd_we, ex_is_load} = {valid_q, rd_we_q, is_load_q};
  assign {ex_pc, ex_imm, ex_op1, ex_op2, ex_rd} = {pc_q, imm_q, op1_q, op2_q, rd_q};

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // event counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, load_use & ~flush & ~hold};
      flush_cnt_q <= flush_cnt_q + {31'd0, flush};
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: randomized and directed checks against a producer-list reference model
module tb_id_ex_operand_stage;
  logic clk = 0, rst_n = 0;
  logic id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
  logic [31:0] id_pc, id_imm, rD1, rD2, ex_wD, mem_wD, wb_wD;
  logic [4:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd, rR1, rR2, ex_rd;
  logic mem_rd_we, wb_rd_we, flush, hold, stall_if_id, ex_valid, ex_rd_we, ex_is_load;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  int m_sc, m_fc;
`endif
  int checks = 0, errors = 0;
  bit m_v, m_we, m_ld;
  logic [31:0] m_pc, m_imm, m_op1, m_op2;
  logic [4:0] m_rd;
  bit m_lu, m_stall;
  logic [31:0] m_o1, m_o2;

  typedef struct {bit live; logic [4:0] rd; logic [31:0] d;} prod_t;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .rR1(rR1), .rR2(rR2),
    .rD1(rD1), .rD2(rD2), .ex_wD(ex_wD), .mem_rd(mem_rd), .mem_rd_we(mem_rd_we),
    .mem_wD(mem_wD), .wb_rd(wb_rd), .wb_rd_we(wb_rd_we), .wb_wD(wb_wD), .flush(flush),
    .hold(hold), .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_rd_we(ex_rd_we),
    .ex_is_load(ex_is_load), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2),
`ifdef ID_EX_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .ex_rd(ex_rd));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // youngest producer first; x0 reads as zero, unused sources pass RF data
  function automatic logic [31:0] resolve(input logic [4:0] rs, input bit used, input logic [31:0] rf);
    prod_t p[3];
    if (rs == 0) return 0;
    if (!used) return rf;
    p[0] = '{m_v && m_we && !m_ld, m_rd, ex_wD};
    p[1] = '{mem_rd_we, mem_rd, mem_wD};
    p[2] = '{wb_rd_we, wb_rd, wb_wD};
    foreach (p[i]) if (p[i].live && p[i].rd == rs) return p[i].d;
    return rf;
  endfunction

  task automatic model_reset();
    {m_v, m_we, m_ld} = 0;
    {m_pc, m_imm, m_op1, m_op2, m_rd} = 0;
`ifdef ID_EX_PERF_CNT_EN
    m_sc = 0; m_fc = 0;
`endif
  endtask

  task automatic idle();
    {id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load} = 0;
    {id_pc, id_imm, rD1, rD2, ex_wD, mem_wD, wb_wD} = 0;
    {id_rs1, id_rs2, id_rd, mem_rd, wb_rd} = 0;
    {mem_rd_we, wb_rd_we, flush, hold} = 0;
  endtask

  task automatic check_regs();
    chk("ex_valid", ex_valid, m_v);
    chk("ex_rd_we", ex_rd_we, m_we);
    chk("ex_is_load", ex_is_load, m_ld);
    if (m_v) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_op1", ex_op1, m_op1);
      chk("ex_op2", ex_op2, m_op2);
      chk("ex_rd", ex_rd, m_rd);
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, m_sc);
    chk("perf_flush", perf_flush_cnt, m_fc);
`endif
  endtask

  // one cycle: settle, check combinational, clock, update model, check registers
  task automatic step();
    #1;
    m_o1 = resolve(id_rs1, id_rs1_used, rD1);
    m_o2 = resolve(id_rs2, id_rs2_used, rD2);
    m_lu = m_v && m_ld && m_we && m_rd != 0 && id_valid &&
           ((id_rs1_used && id_rs1 == m_rd) || (id_rs2_used && id_rs2 == m_rd));
    m_stall = (m_lu || hold) && !flush;
    chk("stall_if_id", stall_if_id, m_stall);
    chk("rR1", rR1, id_rs1);
    chk("rR2", rR2, id_rs2);
    @(posedge clk);
`ifdef ID_EX_PERF_CNT_EN
    if (m_lu && !flush && !hold) m_sc++;
    if (flush) m_fc++;
`endif
    if (flush || (!hold && m_lu)) {m_v, m_we, m_ld} = 0;
    else if (!hold) begin
      m_v = id_valid; m_we = id_valid && id_rd_we; m_ld = id_valid && id_is_load;
      m_pc = id_pc; m_imm = id_imm; m_op1 = m_o1; m_op2 = m_o2; m_rd = id_rd;
    end
    #1;
    check_regs();
  endtask

  task automatic issue(input logic [4:0] rd, input bit ld);
    idle();
    id_valid = 1; id_rd = rd; id_rd_we = 1; id_is_load = ld; id_pc = 32'h100; id_imm = 32'h4;
    step();
  endtask

  logic [31:0] snap_pc, snap_op1;

  initial begin
    idle();
    model_reset();
    #12;
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_op1", ex_op1, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_stall", stall_if_id, 0);
    rst_n = 1;
    @(posedge clk); #1;
    // EX beats MEM
    issue(5, 0);
    idle(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1; ex_wD = 32'h11; mem_rd = 5; mem_rd_we = 1; mem_wD = 32'h22;
    step();
    chk("ex_over_mem", ex_op1, 32'h11);
    // WB forward and x0
    idle(); id_valid = 1; id_rs2 = 7; id_rs2_used = 1; rD2 = 32'h1234; wb_rd = 7; wb_rd_we = 1; wb_wD = 32'hDEAD;
    step();
    chk("wb_fwd", ex_op2, 32'hDEAD);
    idle(); id_valid = 1; id_rs1_used = 1; rD1 = 32'h9; wb_rd_we = 1; wb_wD = 32'h5;
    step();
    chk("x0_zero", ex_op1, 0);
    // load-use: one stall, bubble, then MEM forward
    issue(3, 1);
    idle(); id_valid = 1; id_rs1 = 3; id_rs1_used = 1; rD1 = 32'h1;
    step();
    chk("lu_bubble", ex_valid, 0);
    mem_rd = 3; mem_rd_we = 1; mem_wD = 32'h77;
    step();
    chk("lu_stall_released", stall_if_id, 0);
    chk("lu_mem_fwd", ex_op1, 32'h77);
    // load-use with flush
    issue(3, 1);
    idle(); id_valid = 1; id_rs2 = 3; id_rs2_used = 1; flush = 1;
    step();
    chk("flush_valid", ex_valid, 0);
    // load-use with hold: stall stays, registers frozen
    issue(3, 1);
    snap_pc = ex_pc; snap_op1 = ex_op1;
    idle(); id_valid = 1; id_rs1 = 3; id_rs1_used = 1; id_pc = 32'h999; hold = 1;
    step();
    chk("hold_stall", stall_if_id, 1);
    chk("hold_valid", ex_valid, 1);
    chk("hold_load", ex_is_load, 1);
    chk("hold_pc", ex_pc, snap_pc);
    chk("hold_op1", snap_op1, ex_op1);
    hold = 0;
    step();
    chk("hold_then_bubble", ex_valid, 0);
    // async reset mid-cycle with ex_valid=1
    issue(9, 0);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_we", ex_rd_we, 0);
    chk("mid_rst_pc", ex_pc, 0);
    chk("mid_rst_rd", ex_rd, 0);
    chk("mid_rst_stall", stall_if_id, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    // randomized traffic with small register range to force hazards
    for (int n = 0; n < 3000; n++) begin
      id_valid = ($urandom_range(0, 9) != 0);
      id_pc = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rs1_used = $urandom_range(0, 1); id_rs2_used = $urandom_range(0, 1);
      id_rd = 5'($urandom_range(0, 3)); id_rd_we = $urandom_range(0, 1); id_is_load = $urandom_range(0, 1);
      rD1 = $urandom; rD2 = $urandom; ex_wD = $urandom; mem_wD = $urandom; wb_wD = $urandom;
      mem_rd = 5'($urandom_range(0, 3)); mem_rd_we = $urandom_range(0, 1);
      wb_rd = 5'($urandom_range(0, 3)); wb_rd_we = $urandom_range(0, 1);
      flush = ($urandom_range(0, 9) == 0); hold = ($urandom_range(0, 7) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-side operand collector and ID/EX pipeline register, directly downstream of the register file.
- Drives RF read addresses and takes the raw RF read data.
- Resolves RAW hazards by forwarding from EX/MEM/WB and detects load-use hazards (stall plus bubble).
- Registers the resolved operands and control into the EX stage, with flush and hold.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_imm  in  XLEN  decoded immediate.
- id_rs1, id_rs2  in  RA_W  source registers.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  RA_W  destination.
- id_rd_we  in  1  writes rd.
- id_is_load  in  1  instruction is a load.
- rR1, rR2  out  RA_W  to RF; combinationally equal to id_rs1/id_rs2.
- rD1, rD2  in  XLEN  RF read data (old value during the same-cycle write).
- ex_wD  in  XLEN  ALU result of the instruction currently in EX.
- mem_rd  in  RA_W  MEM destination.
- mem_rd_we  in  1  MEM writes rd.
- mem_wD  in  XLEN  MEM writeback value (load data valid).
- wb_rd  in  RA_W  WB destination.
- wb_rd_we  in  1  WB writes rd.
- wb_wD  in  XLEN  WB data (same as RF wD).
- flush  in  1  branch/jump taken in EX; kill ID.
- hold  in  1  downstream busy; freeze ID/EX.
- stall_if_id  out  1  IF/ID must not advance.
- ex_valid, ex_rd_we, ex_is_load  out  1  registered control.
- ex_pc, ex_imm, ex_op1, ex_op2  out  XLEN  registered data.
- ex_rd  out  RA_W  registered destination.

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, including ex_valid, ex_rd_we, ex_is_load, ex_pc, ex_imm, ex_op1, ex_op2 and ex_rd. stall_if_id depends only on registered state and holds, so it is 0 after reset.
- Forward select per operand (combinational). Applies only if the source is used and nonzero. Priority, first match wins:
  - EX: ex_valid & ex_rd_we & !ex_is_load & ex_rd==rs, gives ex_wD.
  - MEM: mem_rd_we & mem_rd==rs, gives mem_wD.
  - WB: wb_rd_we & wb_rd==rs, gives wb_wD.
  - Otherwise rD1/rD2.
- rs==0 always yields 0, never forwarded.
- load_use = ex_valid & ex_is_load & ex_rd_we & ex_rd!=0 & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- stall_if_id = (load_use | hold) & !flush.
- Clock-edge priority for ID/EX:
  - flush: insert bubble; ex_valid, ex_rd_we and ex_is_load go to 0, data fields don't care (hold previous).
  - else hold: all ID/EX registers keep their value.
  - else load_use: insert bubble (as for flush).
  - else: capture the ID fields and forwarded operands; ex_valid <= id_valid. ex_rd_we and ex_is_load are gated by id_valid.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM and forwarding from mem_wD resolves it.
- hold with load_use: the stall persists, no bubble is inserted, and the hazard is re-evaluated after hold drops.
- Latency: ID operands appear on ex_* 1 cycle after capture.
- Reset mid-operation: all state is cleared immediately; no partial bubble state survives.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt [31:0] and perf_flush_cnt [31:0], both reset to 0.
  - perf_stall_cnt increments each cycle load_use & !flush & !hold.
  - perf_flush_cnt increments each cycle flush=1.
  - Both counters wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with rst_n low mid-cycle while ex_valid=1 -> all ex_* go to 0 immediately, stall_if_id=0.
- EX add x5 (ex_wD=0x11), ID reads rs1=x5, RF rD1=0x0, MEM rd=x5 with 0x22 -> ex_op1=0x11 (EX beats MEM).
- WB writes x7=0xDEAD, ID reads rs2=x7, rD2=0x1234 -> ex_op2=0xDEAD. With rs=x0 and wb_rd=0 writing 0x5 -> operand 0.
- Load x3 in EX, ID uses x3 -> stall_if_id=1 for 1 cycle, ex_valid=0 next cycle. The following cycle, mem_wD=0x77 -> ex_op1=0x77.
- Load-use with flush=1 same cycle -> stall_if_id=0, ex_valid=0. With hold=1 -> all ex_* unchanged and stall_if_id=1.
- ID_EX_PERF_CNT_EN: 3 load-use stalls plus 2 flushes -> perf_stall_cnt=3, perf_flush_cnt=2. Preset counter 0xFFFFFFFF plus one event -> 0.
